// File: rtl/cdb_completion_fifo.sv
// Completion buffer between functional units and the common data bus: accepts up to
// NUM_CH results per cycle into a bounded circular FIFO and broadcasts one per cycle.
module cdb_completion_fifo #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FLUSH,
  input  logic [NUM_CH-1:0]            IN_VALID,
  input  logic [NUM_CH*TAG_W-1:0]      IN_TAG,
  input  logic [NUM_CH*DATA_W-1:0]     IN_DATA,
  output logic                         IN_READY,
  output logic                         CDB_VALID,
  output logic [TAG_W-1:0]             CDB_TAG,
  output logic [DATA_W-1:0]            CDB_DATA,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TAG_W + DATA_W;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [NUM_CH-1:0] accept;
  logic [PW-1:0]     slot [NUM_CH];
  logic [CW-1:0]     push_cnt;
  logic              pop;

  // Ready depends only on the registered count, so producers see no path from IN_VALID.
  assign IN_READY = (count <= CW'(DEPTH - NUM_CH));
  assign accept   = IN_VALID & {NUM_CH{IN_READY}};
  assign pop      = (count != '0);
  assign COUNT    = count;

  // Prefix popcount compresses out idle channels into consecutive slots.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      slot[i] = wr_ptr + acc[PW-1:0];
      if (accept[i]) acc = acc + CW'(1);
    end
    push_cnt = acc;
  end

  always_ff @(posedge CLK) begin
    if (!RST && !FLUSH) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) mem[slot[i]] <= {IN_TAG[i*TAG_W +: TAG_W], IN_DATA[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      CDB_VALID <= 1'b0;
      CDB_TAG   <= '0;
      CDB_DATA  <= '0;
    end else if (FLUSH) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      CDB_VALID <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + push_cnt[PW-1:0];
      count  <= count + push_cnt - CW'(pop);
      if (pop) begin
        {CDB_TAG, CDB_DATA} <= mem[rd_ptr];
        rd_ptr              <= rd_ptr + PW'(1);
        CDB_VALID           <= 1'b1;
      end else begin
        CDB_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_completion_fifo.sv
// Directed bench for cdb_completion_fifo with NUM_CH=4, DEPTH=16: reset, ordering,
// back-pressure with pointer wrap, flush, and push/pop at the ready boundary.
module tb_cdb_completion_fifo;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic                     CLK = 1'b0;
  logic                     RST;
  logic                     FLUSH;
  logic [NUM_CH-1:0]        IN_VALID;
  logic [NUM_CH*TAG_W-1:0]  IN_TAG;
  logic [NUM_CH*DATA_W-1:0] IN_DATA;
  logic                     IN_READY;
  logic                     CDB_VALID;
  logic [TAG_W-1:0]         CDB_TAG;
  logic [DATA_W-1:0]        CDB_DATA;
  logic [4:0]               COUNT;

  int n_chk  = 0;
  int n_pass = 0;

  cdb_completion_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_TAG(IN_TAG),
    .IN_DATA(IN_DATA), .IN_READY(IN_READY), .CDB_VALID(CDB_VALID), .CDB_TAG(CDB_TAG),
    .CDB_DATA(CDB_DATA), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    IN_TAG[ch*TAG_W +: TAG_W]    = t;
    IN_DATA[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic push(input logic [NUM_CH-1:0] v, input int base);
    IN_VALID = v;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, TAG_W'(base + c), DATA_W'(32'h100 + base + c));
    tick();
    IN_VALID = '0;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_d;
  logic [TAG_W-1:0] exp_t;

  initial begin
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = '0; IN_TAG = '0; IN_DATA = '0;

    // 1. reset with all channels valid
    IN_VALID = 4'b1111;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, TAG_W'(c + 9), 32'hAAAA0000 + c);
    tick(); tick();
    RST = 1'b0; IN_VALID = '0;
    chk("rst_count", COUNT, 0);
    chk("rst_valid", CDB_VALID, 0);
    chk("rst_tag", CDB_TAG, 0);
    chk("rst_data", CDB_DATA, 0);
    chk("rst_ready", IN_READY, 1);
    tick();
    chk("rst_nocap_valid", CDB_VALID, 0);
    chk("rst_nocap_count", COUNT, 0);

    // 2. single result on channel 2
    IN_VALID = 4'b0100;
    set_ch(2, 4'd5, 32'hDEADBEEF);
    tick();
    IN_VALID = '0;
    chk("single_nobypass", CDB_VALID, 0);
    chk("single_count", COUNT, 1);
    tick();
    chk("single_valid", CDB_VALID, 1);
    chk("single_tag", CDB_TAG, 5);
    chk("single_data", CDB_DATA, 32'hDEADBEEF);
    chk("single_count0", COUNT, 0);
    tick();
    chk("single_valid_off", CDB_VALID, 0);

    // 3. ordering and compression, channel 2 idle
    IN_VALID = 4'b1011;
    set_ch(0, 4'd1, 32'h11); set_ch(1, 4'd2, 32'h22);
    set_ch(2, 4'd3, 32'h33); set_ch(3, 4'd4, 32'h44);
    tick();
    IN_VALID = '0;
    chk("ord_count_peak", COUNT, 3);
    chk("ord_valid0", CDB_VALID, 0);
    tick();
    chk("ord_v1", CDB_VALID, 1); chk("ord_t1", CDB_TAG, 1); chk("ord_d1", CDB_DATA, 32'h11);
    tick();
    chk("ord_v2", CDB_VALID, 1); chk("ord_t2", CDB_TAG, 2); chk("ord_d2", CDB_DATA, 32'h22);
    tick();
    chk("ord_v3", CDB_VALID, 1); chk("ord_t3", CDB_TAG, 4); chk("ord_d3", CDB_DATA, 32'h44);
    chk("ord_count_end", COUNT, 0);
    tick();
    chk("ord_idle", CDB_VALID, 0);

    // 4. saturating input, producer holds while not ready
    begin
      int seq = 0;
      int bc = 0;
      int maxc = 0;
      bit saw_nr = 0;
      for (int cyc = 0; cyc < 120; cyc++) begin
        bit feed;
        feed = (cyc < 40);
        if (feed) begin
          IN_VALID = 4'b1111;
          for (int c = 0; c < NUM_CH; c++) begin
            logic [31:0] v;
            v = 32'(seq + c);
            set_ch(c, v[TAG_W-1:0], v);
          end
          if (IN_READY) begin
            for (int c = 0; c < NUM_CH; c++) q.push_back(32'(seq + c));
            seq += NUM_CH;
          end
        end else begin
          IN_VALID = '0;
        end
        tick();
        if (CDB_VALID) begin
          if (q.size() == 0) chk("bp_spurious", 1, 0);
          else begin
            exp_d = q.pop_front();
            exp_t = exp_d[TAG_W-1:0];
            chk("bp_tag", CDB_TAG, exp_t);
            chk("bp_data", CDB_DATA, exp_d);
            bc++;
          end
        end
        chk("bp_count", COUNT, q.size());
        chk("bp_ready", IN_READY, (COUNT <= 12));
        if (int'(COUNT) > maxc) maxc = int'(COUNT);
        if (!IN_READY) saw_nr = 1;
        if (!feed && q.size() == 0) break;
      end
      IN_VALID = '0;
      chk("bp_drained", q.size(), 0);
      chk("bp_total_ge40", (bc >= 40), 1);
      chk("bp_max_le16", (maxc <= 16), 1);
      chk("bp_saw_notready", saw_nr, 1);
    end
    tick();
    chk("bp_idle", CDB_VALID, 0);

    // 5. flush at COUNT=9 with a push in the flush cycle
    push(4'b1111, 0);
    push(4'b1111, 4);
    push(4'b0111, 8);
    chk("fl_count9", COUNT, 9);
    FLUSH = 1'b1;
    IN_VALID = 4'b0001;
    set_ch(0, 4'hA, 32'h00000BAD);
    tick();
    FLUSH = 1'b0; IN_VALID = '0;
    chk("fl_count0", COUNT, 0);
    chk("fl_valid0", CDB_VALID, 0);
    chk("fl_ready", IN_READY, 1);
    tick();
    chk("fl_no_bcast", CDB_VALID, 0);
    chk("fl_count_idle", COUNT, 0);
    IN_VALID = 4'b0010;
    set_ch(1, 4'd7, 32'h1234);
    tick();
    IN_VALID = '0;
    tick();
    chk("fl_next_v", CDB_VALID, 1);
    chk("fl_next_t", CDB_TAG, 7);
    chk("fl_next_d", CDB_DATA, 32'h1234);
    tick();
    chk("fl_next_off", CDB_VALID, 0);

    // 6. push 4 + pop 1 at COUNT=12
    push(4'b1111, 0);
    push(4'b1111, 4);
    push(4'b1111, 8);
    push(4'b0111, 12);
    chk("bd_count12", COUNT, 12);
    chk("bd_ready12", IN_READY, 1);
    push(4'b1111, 0);
    chk("bd_count15", COUNT, 15);
    chk("bd_ready15", IN_READY, 0);
    tick();
    chk("bd_count14", COUNT, 14);
    chk("bd_ready14", IN_READY, 0);
    tick();
    chk("bd_count13", COUNT, 13);
    chk("bd_ready13", IN_READY, 0);
    tick();
    chk("bd_count12b", COUNT, 12);
    chk("bd_ready12b", IN_READY, 1);
    for (int i = 0; i < 12; i++) tick();
    chk("bd_empty", COUNT, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_completion_fifo.md
# cdb_completion_fifo

Parametrised completion buffer between the functional units (loads, ALUs, any later additions) and the common data bus. Accepts up to NUM_CH results per cycle. Holds them in a circular FIFO of DEPTH entries. Broadcasts exactly one result per cycle on a registered CDB port. Unlike the first-generation queue, it is bounded, applies back-pressure to producers, supports a pipeline flush, and has fully synchronous reset.

## Interface
Parameters:
- NUM_CH, default 4: number of producer channels; range 1..8.
- DEPTH, default 16: FIFO entries; power of two, DEPTH >= NUM_CH.
- DATA_W, default 32: result data width.
- TAG_W, default 4: reservation-station tag width.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous discard of all buffered results (mispredict recovery).
- IN_VALID  in  NUM_CH  per-channel result valid.
- IN_TAG  in  NUM_CH*TAG_W  per-channel tag; channel i occupies bits [i*TAG_W +: TAG_W].
- IN_DATA  in  NUM_CH*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- IN_READY  out  1  common ready for all channels.
- CDB_VALID  out  1  broadcast valid.
- CDB_TAG  out  TAG_W  broadcast tag.
- CDB_DATA  out  DATA_W  broadcast data.
- COUNT  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH-entry array of {tag, data}.
  - Read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy count is held explicitly.
- IN_READY = (DEPTH - count) >= NUM_CH.
  - Computed from registered count only; no combinational path from IN_VALID.
- Push:
  - Channel i is accepted when IN_VALID[i] && IN_READY.
  - Accepted entries are written in ascending channel index to consecutive slots starting at wr_ptr.
  - wr_ptr advances by the number accepted (popcount).
  - Gaps from non-valid channels are compressed out.
- Producer behaviour when IN_READY=0: hold its result and keep IN_VALID asserted.
  - Results are never dropped while IN_READY=1.
- Pop: when count != 0, the head entry is loaded into the CDB output registers and rd_ptr advances by 1.
  - CDB_VALID is set for that cycle.
  - When count == 0, CDB_VALID is 0; CDB_TAG/CDB_DATA hold their previous values.
- Count update: count_next = count + pushes - pop, evaluated in the same cycle.
  - Push and pop in one cycle are legal, including at count == DEPTH-NUM_CH.
- No bypass: an empty FIFO does not forward inputs directly to the CDB.
- FLUSH (priority below RST, above push/pop):
  - count, rd_ptr, wr_ptr are set to 0 and CDB_VALID is set to 0 on the next edge.
  - Inputs presented in the FLUSH cycle are discarded.
  - Array contents are not cleared.
- RST, all outputs and state:
  - count, rd_ptr, wr_ptr = 0; CDB_VALID = 0; CDB_TAG = 0; CDB_DATA = 0.
  - IN_READY = 1 after the reset edge, since count = 0.
  - RST mid-operation discards all contents identically.
- Ordering: results are broadcast in FIFO order. Within one cycle, lower channel index goes first.

## Timing
- Results pushed at edge k appear on the CDB after edge k+1 at the earliest, i.e. 1-cycle latency through an empty FIFO.
- Throughput: one broadcast per cycle.
  - Sustained input above 1 result/cycle fills the FIFO.
  - IN_READY deasserts once free slots < NUM_CH.
- IN_READY and COUNT change only after a clock edge.
- CDB_VALID is high for exactly one cycle per entry; there is no CDB back-pressure.
- FLUSH or RST asserted at edge k: CDB_VALID = 0 and IN_READY = 1 after edge k.

## Test plan
All scenarios use NUM_CH=4, DEPTH=16.

1. Reset: assert RST for 2 cycles with IN_VALID=4'b1111.
   - Required: COUNT=0, CDB_VALID=0, CDB_TAG=0, CDB_DATA=0, IN_READY=1 after release; no entry captured.
2. Single result: IN_VALID=4'b0100, tag 5, data 0xDEADBEEF for one cycle at edge k.
   - Required: CDB_VALID=1, tag 5, data 0xDEADBEEF after edge k+1 only; CDB_VALID=0 after edge k+2.
3. Ordering and compression: one cycle of IN_VALID=4'b1011 with tags 1, 2, (3 invalid), 4.
   - Required: CDB broadcasts tags 1, 2, 4 on three consecutive cycles; COUNT peaks at 3.
4. Full/back-pressure: IN_VALID=4'b1111 every cycle.
   - Required: IN_READY falls once COUNT > 12; COUNT never exceeds 16.
   - Required: all accepted tags are broadcast in order with none lost or duplicated.
   - Required: pointers wrap past slot 15 correctly (run 40 or more results).
5. Flush: fill COUNT to 9, assert FLUSH with IN_VALID=4'b0001 in the same cycle.
   - Required: COUNT=0 and CDB_VALID=0 after that edge; the flush-cycle input is never broadcast.
   - Required: next push after release is broadcast normally.
6. Simultaneous push/pop at boundary: COUNT=12, push 4, pop 1.
   - Required: COUNT=15, IN_READY=0.
   - Required: on the following idle cycle COUNT=14, and IN_READY stays 0 until COUNT <= 12.
